// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute sequencing, datapath controls,
// memory-wait timeout and retired-instruction count. Define MIPS_CTRL_BNE_EN to accept bne.
//   state    | meaning
//   IDLE     | waiting for start
//   FETCH    | instruction read, PC+4 on mem_ready
//   DECODE   | branch target into ALUOut, dispatch on opcode
//   R_EXEC   | R-type ALU operation
//   R_WB     | R-type result to rd
//   MEM_ADDR | lw/sw effective address
//   MEM_RD   | data read
//   MEM_WB   | MDR to rt
//   MEM_WR   | data write
//   I_EXEC   | addi/slti ALU operation
//   I_WB     | immediate result to rt
//   BRANCH   | beq/bne compare and conditional PC load
//   JUMP     | j
//   JAL      | jal: jump and link to $31
//   JR       | jr
//   HALT     | stopped with err_code, exit by rst only
module mips_multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
        S_MEM_WR, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [1:0]        err_q, err_nxt;
    logic              wait_state, timeout, retire;
`ifdef MIPS_CTRL_BNE_EN
    logic              is_bne, is_bne_nxt;
`endif

    // Timeout fires on the cycle that would bring the count to TIMEOUT_CYCLES.
    assign wait_state   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout      = wait_state && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign wait_cnt_nxt = (wait_state && !mem_ready && !timeout) ? wait_cnt + WAIT_W'(1) : '0;
    assign retire       = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);
    assign err_code     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            err_q       <= ERR_NONE;
            instr_count <= '0;
`ifdef MIPS_CTRL_BNE_EN
            is_bne      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
            if (retire) instr_count <= instr_count + CNT_W'(1);
`ifdef MIPS_CTRL_BNE_EN
            is_bne   <= is_bne_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = err_q;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_source  = 2'b00;
        halted     = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
        is_bne_nxt = is_bne;
`endif
        case (state)
            S_IDLE: if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
`ifdef MIPS_CTRL_BNE_EN
                is_bne_nxt = (opcode == OP_BNE);
`endif
                case (opcode)
                    OP_RTYPE:     state_nxt = (funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_nxt = S_BRANCH;
`endif
                    OP_ADDI, OP_SLTI: state_nxt = S_I_EXEC;
                    OP_J:         state_nxt = S_JUMP;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        state_nxt = S_HALT;
                        err_nxt   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                state_nxt = S_R_WB;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    default: begin
                        state_nxt = S_HALT;
                        err_nxt   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                state_nxt = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_nxt = S_MEM_WB;
                else if (timeout) begin
                    state_nxt = S_HALT;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
                else if (timeout) begin
                    state_nxt = S_HALT;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_nxt = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
                pc_en     = zero ^ is_bne;
`else
                pc_en     = zero;
`endif
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                state_nxt  = S_FETCH;
            end
            S_JR: begin
                pc_source = 2'b11;
                pc_en     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Control FSM for a multi-cycle version of the team's MIPS datapath.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, write enable and ALU operation.
- Handshakes with a unified instruction/data memory through mem_ready. Counts retired instructions, and halts on an illegal instruction or a memory timeout.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles a memory state may wait for mem_ready before halting with an error.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; leaves IDLE and begins fetching
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_en  out  1  PC load enable
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  2  write register: 00=rt, 01=rd, 10=$31
- mem_to_reg  out  2  write data: 00=ALUOut, 01=MDR, 10=PC
- reg_write  out  1  regfile write enable
- alu_src_a  out  1  ALU A input: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B input: 00=B reg, 01=4, 10=sext, 11=sext<<2
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pc_source  out  2  next PC: 00=ALU, 01=ALUOut, 10=jump target, 11=A reg
- halted  out  1  FSM is in HALT
- err_code  out  2  00 none, 01 illegal instruction, 10 memory timeout
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
Reset:
- State goes to IDLE. instr_count=0, err_code=00, wait counter=0.
- All outputs are 0 except alu_op=010.
- rst mid-instruction aborts immediately with no writes.

Outputs:
- Moore outputs decode from state. In any state, every output not listed takes its reset value.

State sequence:
- IDLE: start=1 -> FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_en are asserted only in the cycle mem_ready=1 (Mealy); then -> DECODE.
  - Otherwise the FSM holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD, which stores the branch target in ALUOut. Dispatch on opcode:
  - 000000 (R-type) -> R_EXEC, or JR if funct=001000.
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) or 001010 (slti) -> I_EXEC.
  - 000010 (j) -> JUMP.
  - 000011 (jal) -> JAL.
  - anything else -> HALT with err 01.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_op from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Other funct -> HALT with err 01; otherwise -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. mem_ready -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD (addi) or SLT (slti) -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_en=zero -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- JAL: pc_source=10, pc_en=1, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH. PC still holds PC+4 when the write samples.
- JR: pc_source=11, pc_en=1 -> FETCH.
- HALT: halted=1. err_code holds its value; exit only via rst. start is ignored.

Wait counter:
- In FETCH, MEM_RD and MEM_WR the wait counter increments each cycle mem_ready=0 and clears on state exit.
- When the counter reaches TIMEOUT_CYCLES with mem_ready still 0 -> HALT, err 10. The request is dropped that cycle.

Retired-instruction counter:
- instr_count increments on each transition into FETCH from any state except IDLE, and wraps modulo 2^CNT_W.

Latencies with mem_ready tied to 1, in cycles:
- R-type 4, addi/slti 4, lw 5, sw 4, beq 3, j/jal/jr 3.

Other rules:
- start is ignored outside IDLE.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) -> BRANCH with a registered is_bne flag. In BRANCH, pc_en = zero XOR is_bne.
- Undefined: 000101 is illegal -> HALT with err 01.

Test Plan:
- Reset, then start with mem_ready=1 and opcode=0, funct=100000: states FETCH, DECODE, R_EXEC, R_WB. R_WB shows reg_write=1, reg_dst=01, alu_op=010 one cycle earlier in R_EXEC; instr_count=1 on return to FETCH.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD: mem_read=1 and i_or_d=1 held 4 cycles; MEM_WB shows mem_to_reg=01; total 8 cycles.
- beq with zero=1: pc_en=1 and pc_source=01 in BRANCH. With zero=0: pc_en=0. Both retire in 3 cycles.
- jal: JAL cycle shows reg_dst=10, mem_to_reg=10, reg_write=1, pc_en=1, pc_source=10.
- opcode=111111: HALT after DECODE, halted=1, err_code=01. start is ignored; rst clears to IDLE.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=16: HALT, err_code=10 after 16 wait cycles. With MIPS_CTRL_BNE_EN defined, bne with zero=0 gives pc_en=1.
